// File: rtl/grf_wb_arbiter.sv
// grf_wb_arbiter
//   Single write-port arbiter for the 32x32 general register file. The
//   pipeline writeback always wins the port; multiply/divide results are
//   parked in an in-order queue and drained into cycles the pipeline leaves
//   idle. A pipeline write to a register kills older queued results for that
//   register, so a stale MD value can never overwrite a newer one.
//
// Ports
//   clk, reset       : clock, synchronous active-high reset
//   wb_we/reg/data   : pipeline writeback (never back-pressured)
//   md_valid/ready   : MD result handshake; md_reg/md_data carry the result
//   grf_we/wreg/wdata: GRF write port (combinational select)
//   pending_mask     : one bit per register with a live queued write
//   pipe_stall       : registered request to freeze the pipeline (starvation)
//   q_count          : occupied queue slots, live and dead
module grf_wb_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_we,
  input  logic [4:0]               wb_reg,
  input  logic [31:0]              wb_data,
  input  logic                     md_valid,
  output logic                     md_ready,
  input  logic [4:0]               md_reg,
  input  logic [31:0]              md_data,
  output logic                     grf_we,
  output logic [4:0]               grf_wreg,
  output logic [31:0]              grf_wdata,
  output logic [31:0]              pending_mask,
  output logic                     pipe_stall,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [7:0]       STARVE_C = 8'(STARVE_MAX);

  // Queue storage: live flag is control (reset), reg/data are payload (not reset).
  logic [DEPTH-1:0] q_live;
  logic [4:0]       q_reg  [DEPTH];
  logic [31:0]      q_data [DEPTH];

  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic [7:0]       age;
  logic             stall_r;

  logic       head_valid, head_live, head_dead;
  logic       wb_write, head_write, pop, enq;
  logic [7:0] age_next;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign head_valid = (count != '0);
  assign head_live  = head_valid & q_live[rd_ptr];
  assign head_dead  = head_valid & ~q_live[rd_ptr];
  // A write to $0 is architecturally a no-op, so it leaves the port free.
  assign wb_write   = wb_we & (wb_reg != 5'd0);
  assign head_write = head_live & ~wb_write;
  // Dead heads retire without using the port, even alongside a wb write.
  assign pop        = head_write | head_dead;
  // Registered-state only: a same-cycle pop never opens a slot early.
  assign md_ready   = (count < DEPTH_C);
  assign enq        = md_valid & md_ready & (md_reg != 5'd0);
  // Age only grows while a live head is actually blocked by the pipeline.
  assign age_next   = (head_live & wb_write) ? sat_inc(age) : 8'd0;

  assign q_count    = count;
  assign pipe_stall = stall_r;

  always_comb begin
    grf_we    = 1'b0;
    grf_wreg  = 5'd0;
    grf_wdata = 32'd0;
    if (wb_write) begin
      grf_we    = 1'b1;
      grf_wreg  = wb_reg;
      grf_wdata = wb_data;
    end else if (head_live) begin
      grf_we    = 1'b1;
      grf_wreg  = q_reg[rd_ptr];
      grf_wdata = q_data[rd_ptr];
    end
  end

  // Live bits are cleared on pop, so a set live bit always means an occupied slot.
  always_comb begin
    pending_mask = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_live[i]) pending_mask[q_reg[i]] = 1'b1;
    end
  end

  // Queue control, starvation tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      q_live  <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      age     <= 8'd0;
      stall_r <= 1'b0;
    end else begin
      // Squash first; the enqueue below overrides it so a same-cycle MD
      // result (newer than the wb write) stays live.
      for (int i = 0; i < DEPTH; i++) begin
        if (wb_write && (q_reg[i] == wb_reg)) q_live[i] <= 1'b0;
      end
      if (pop) begin
        q_live[rd_ptr] <= 1'b0;
        rd_ptr         <= rd_ptr + PTR_W'(1);
      end
      if (enq) begin
        q_live[wr_ptr] <= 1'b1;
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end
      case ({enq, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      age     <= age_next;
      stall_r <= (age_next >= STARVE_C);
    end
  end

  // Queue payload
  always_ff @(posedge clk) begin
    if (enq) begin
      q_reg[wr_ptr]  <= md_reg;
      q_data[wr_ptr] <= md_data;
    end
  end

endmodule
